// File: rtl/addsub_arbiter.sv
// addsub_arbiter: one shared 64-bit add/sub/slt/sltu unit serving two execute lanes.
// A round-robin arbiter grants at most one request per cycle.
// Each lane owns a one-entry registered response slot.
module addsub_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_in1,
    input  logic [63:0] req0_in2,
    input  logic [1:0]  req0_op,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_in1,
    input  logic [63:0] req1_in2,
    input  logic [1:0]  req1_op,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_out,
    output logic        rsp0_cout,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_out,
    output logic        rsp1_cout
);

    typedef enum logic {
        Pri0 = 1'b0,
        Pri1 = 1'b1
    } pri_t;

    localparam pri_t PriReset = RR_INIT ? Pri1 : Pri0;

    pri_t        pri_q;
    logic        elig0, elig1;
    logic        grant0, grant1;
    logic [63:0] op_a, op_b;
    logic [1:0]  op_sel;
    logic [64:0] sum, diff;
    logic        lt_s, lt_u;
    logic [63:0] res;
    logic        res_cout;

    // A lane may issue only if its response slot is empty or emptying this cycle.
    always_comb begin
        elig0  = req0_valid && (!rsp0_valid || rsp0_ready);
        elig1  = req1_valid && (!rsp1_valid || rsp1_ready);
        grant0 = !rst && elig0 && (!elig1 || (pri_q == Pri0));
        grant1 = !rst && elig1 && (!elig0 || (pri_q == Pri1));
        req0_ready = grant0;
        req1_ready = grant1;
    end

    // Shared datapath on the granted lane's operands.
    always_comb begin
        op_a   = grant1 ? req1_in1 : req0_in1;
        op_b   = grant1 ? req1_in2 : req0_in2;
        op_sel = grant1 ? req1_op  : req0_op;
        sum    = {1'b0, op_a} + {1'b0, op_b};
        diff   = {1'b0, op_a} - {1'b0, op_b};
        // Borrow out of the 65-bit subtract is the unsigned less-than.
        lt_u   = diff[64];
        // With differing signs the negative operand is smaller; otherwise no overflow.
        lt_s   = (op_a[63] != op_b[63]) ? op_a[63] : diff[63];
        res      = 64'd0;
        res_cout = 1'b0;
        unique case (op_sel)
            2'b00: begin
                res      = sum[63:0];
                res_cout = sum[64];
            end
            2'b01: begin
                res      = diff[63:0];
                res_cout = diff[64];
            end
            2'b10: res = {63'd0, lt_s};
            2'b11: res = {63'd0, lt_u};
            default: ;
        endcase
    end

    // Round-robin priority: hand priority to the other lane after every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q <= PriReset;
        end else if (grant0) begin
            pri_q <= Pri1;
        end else if (grant1) begin
            pri_q <= Pri0;
        end
    end

    // Slot 0: a grant overwrites (even while draining), otherwise a drain empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_out   <= 64'd0;
            rsp0_cout  <= 1'b0;
        end else if (grant0) begin
            rsp0_valid <= 1'b1;
            rsp0_out   <= res;
            rsp0_cout  <= res_cout;
        end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
        end
    end

    // Slot 1: same policy as slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp1_valid <= 1'b0;
            rsp1_out   <= 64'd0;
            rsp1_cout  <= 1'b0;
        end else if (grant1) begin
            rsp1_valid <= 1'b1;
            rsp1_out   <= res;
            rsp1_cout  <= res_cout;
        end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
        end
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Shares one 64-bit add/sub/compare unit between two requesters (integer execute lane 0 and lane 1) using a round-robin arbiter. At most one operation issues per cycle. Each lane has its own valid/ready request port and its own one-entry registered response slot. The block sits between the issue stage and writeback and contains the only add/sub/slt datapath on that path.

## Interface
- `RR_INIT`, default 0: requester that holds priority after reset (0 or 1).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `reqN_valid`  in  1  request from lane N (N = 0, 1) is present.
- `reqN_ready`  out  1  request from lane N is accepted this cycle; combinational.
- `reqN_in1`  in  64  first operand.
- `reqN_in2`  in  64  second operand.
- `reqN_op`  in  2  operation: 00 add, 01 sub, 10 slt (signed), 11 sltu (unsigned).
- `rspN_valid`  out  1  response slot N holds a result.
- `rspN_ready`  in  1  lane N consumes the response this cycle.
- `rspN_out`  out  64  result.
- `rspN_cout`  out  1  carry/borrow out.

## Operation
**Datapath**
- Combinational 65-bit add/sub on the granted operands.
- add: `{cout, out} = in1 + in2`.
- sub: `{cout, out} = in1 - in2` taken at 65 bits, so `cout` = 1 exactly when in1 < in2 unsigned.
- slt: `out = 1` if `$signed(in1) < $signed(in2)`, else 0; `cout = 0`.
- sltu: `out = 1` if in1 < in2 unsigned, else 0; `cout = 0`.

**Eligibility**
- Lane N is eligible when `reqN_valid` is high and slot N is free or draining this cycle.
- Free means `rspN_valid = 0`; draining means `rspN_valid && rspN_ready`.

**Arbiter**
- 1-bit priority state with two states, PRI0 and PRI1.
- Only one lane eligible: that lane is granted.
- Both lanes eligible: the lane named by the priority state is granted.
- Neither lane eligible: no grant.
- `reqN_ready` = grant to lane N. At most one `ready` is high per cycle.
- After any grant, priority moves to the other lane (PRI0→PRI1 after a lane-0 grant, PRI1→PRI0 after a lane-1 grant). With no grant, priority holds.

**Response slot N (per edge)**
- Grant to N: load `out` and `cout` into slot N and set `rspN_valid = 1`. This applies even if the old entry drains on the same edge; the new entry replaces it with no bubble.
- Drain only (`rspN_ready` with valid, no grant): clear `rspN_valid`. Data is held but has no meaning.
- `rspN_out` and `rspN_cout` stay stable while `rspN_valid && !rspN_ready`.
- Requesters hold `reqN_*` stable until `ready`. The block does not check this.

## Timing
**Reset**
- Values: `rspN_valid = 0`, `rspN_out = 0`, `rspN_cout = 0`, priority = `RR_INIT`.
- `reqN_ready` is 0 during any cycle in which `rst` is high.
- Reset mid-operation drops both slots' contents with no response.

**Latency and throughput**
- Request accepted at edge k → `rspN_valid` high in cycle k+1, with the result visible from that edge.
- Total throughput is 1 op/cycle.
- Per lane: 1 op/cycle while that lane's `rspN_ready` stays high and it wins arbitration.

**Boundary conditions**
- Both lanes continuously valid with both slots draining: grants strictly alternate, giving each lane 1 op per 2 cycles.
- Slot full and not draining: that lane's `ready` stays 0, and the other lane may be granted the same cycle.
- Arbitration is work-conserving: no idle cycle while any lane is eligible.
- `rspN_ready` while `rspN_valid = 0`: ignored.

## Test plan
- **Reset:** `rst` high 2 cycles with both `reqN_valid` = 1 → both `ready` = 0, `rspN_valid` = 0, outputs = 0. First grant after release goes to lane `RR_INIT`.
- **Arithmetic on lane 0:**
  - add 0xFFFFFFFFFFFFFFFF + 1 → `out` = 0, `cout` = 1.
  - sub 5 - 7 → `out` = 0xFFFFFFFFFFFFFFFE, `cout` = 1.
  - slt −1 vs 1 → `out` = 1.
  - sltu −1 vs 1 → `out` = 0, `cout` = 0.
  - Each response appears exactly 1 cycle after acceptance.
- **Contention:** both lanes valid for 6 cycles with `rspN_ready` = 1 and `RR_INIT` = 0 → grant sequence 0,1,0,1,0,1; each result is routed to the correct slot.
- **Backpressure:** `rsp0_ready` = 0 with slot 0 full and both requesting → `req0_ready` = 0 and lane 1 is granted every cycle. Raising `rsp0_ready` → lane 0 is granted in that same cycle and its slot is replaced with no bubble.
- **Mid-operation reset:** `rst` asserted while `rsp1_valid` = 1 → `rsp1_valid` = 0 next cycle and priority returns to `RR_INIT`.
